// File: rtl/csr_trap_sequencer_pkg.sv
// Shared constants for the CSR trap sequencer: CSR addresses, exception
// codes, mstatus field positions, sequencer state encodings and the
// XLEN-code-to-width helper.
package csr_trap_sequencer_pkg;

   // XLEN is carried as a code; the data width is 1 << (code + 4)
   localparam int XLEN_32B = 1;
   localparam int XLEN_64B = 2;

   function automatic int xlen_width(input int xlen);
      return 1 << (xlen + 4);
   endfunction

   // CSR addresses
   localparam logic [11:0] REG_MSTATUS_ADDR = 12'h300;
   localparam logic [11:0] REG_MTVEC_ADDR   = 12'h305;
   localparam logic [11:0] REG_MEPC_ADDR    = 12'h341;
   localparam logic [11:0] REG_MCAUSE_ADDR  = 12'h342;
   localparam logic [11:0] REG_MTVAL_ADDR   = 12'h343;

   // Synchronous exception codes (mcause, interrupt bit clear)
   localparam logic [4:0] E_INSTR_MISALIGN = 5'd0;
   localparam logic [4:0] E_INSTR_FAULT    = 5'd1;
   localparam logic [4:0] E_ILLEGAL_INSTR  = 5'd2;
   localparam logic [4:0] E_BREAKPOINT     = 5'd3;
   localparam logic [4:0] E_LOAD_MISALIGN  = 5'd4;
   localparam logic [4:0] E_LOAD_FAULT     = 5'd5;
   localparam logic [4:0] E_STORE_MISALIGN = 5'd6;
   localparam logic [4:0] E_STORE_FAULT    = 5'd7;
   localparam logic [4:0] E_ECALL_M        = 5'd11;

   // mstatus fields touched by trap entry / MRET
   localparam int MSTATUS_MIE_BIT  = 3;
   localparam int MSTATUS_MPIE_BIT = 7;
   localparam int MSTATUS_MPP_HI   = 12;
   localparam int MSTATUS_MPP_LO   = 11;

   // Sequencer states; one CSR write per state except IDLE and REDIR
   typedef enum logic [2:0] {
      SEQ_IDLE      = 3'd0,
      SEQ_T_MEPC    = 3'd1,
      SEQ_T_MCAUSE  = 3'd2,
      SEQ_T_MTVAL   = 3'd3,
      SEQ_T_MSTATUS = 3'd4,
      SEQ_M_MSTATUS = 3'd5,
      SEQ_REDIR     = 3'd6
   } seq_state_e;

endpackage

// File: rtl/csr_trap_sequencer_mstatus_xform.sv
// Combinational mstatus update for trap entry (stack MIE into MPIE, clear
// MIE) and MRET (restore MIE from MPIE, set MPIE). MPP is always machine.
module csr_mstatus_xform
   import csr_trap_sequencer_pkg::*;
#(
   parameter  int XLEN = XLEN_64B,
   localparam int W    = xlen_width(XLEN)
) (
   input  logic [W-1:0] i_mstatus,
   input  logic         i_mret,
   output logic [W-1:0] o_mstatus
);

   // Derive the new mstatus from the live value
   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      o_mstatus = i_mstatus;
      o_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      if (i_mret) begin
         o_mstatus[MSTATUS_MIE_BIT]  = i_mstatus[MSTATUS_MPIE_BIT];
         o_mstatus[MSTATUS_MPIE_BIT] = 1'b1;
      end else begin
         o_mstatus[MSTATUS_MPIE_BIT] = i_mstatus[MSTATUS_MIE_BIT];
         o_mstatus[MSTATUS_MIE_BIT]  = 1'b0;
      end
   end

endmodule

// File: rtl/csr_trap_sequencer.sv
// Owner of the CSR-file write port. Passes pipeline CSR writes through in
// IDLE and otherwise runs the trap-entry / MRET update sequence, stalling the
// pipeline and finishing with a one-cycle redirect + flush.
// Build option: define CSR_SEQ_MTVAL_EN to include the mtval write state.
module csr_trap_sequencer
   import csr_trap_sequencer_pkg::*;
#(
   parameter  int XLEN = XLEN_64B,
   localparam int W    = xlen_width(XLEN)
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_trap_req,
   input  logic [4:0]   i_trap_cause,
   input  logic [W-1:0] i_trap_pc,
   input  logic [W-1:0] i_trap_tval,
   input  logic         i_mret_req,
   input  logic         i_instr_csr_we,
   input  logic [11:0]  i_instr_csr_addr,
   input  logic [W-1:0] i_instr_csr_data,
   input  logic [W-1:0] i_mtvec,
   input  logic [W-1:0] i_mepc,
   input  logic [W-1:0] i_mstatus,
   output logic         o_trap_ack,
   output logic         o_mret_ack,
   output logic         o_instr_csr_grant,
   output logic         o_csr_we,
   output logic [11:0]  o_csr_addr,
   output logic [W-1:0] o_csr_wdata,
   output logic         o_stall,
   output logic         o_flush,
   output logic         o_redirect_valid,
   output logic [W-1:0] o_redirect_pc
);

   seq_state_e   r_state;
   logic [4:0]   r_cause;
   logic [W-3:0] r_pc_hi;
   logic         r_is_trap;
   logic [W-1:0] w_mstatus_new;
   logic         w_unused;

`ifdef CSR_SEQ_MTVAL_EN
   logic [W-1:0] r_tval;
   // Low address bits are forced to zero wherever they are consumed
   assign w_unused = ^{i_trap_pc[1:0], i_mtvec[1:0], i_mepc[1:0]};
`else
   // Without the mtval state the faulting address is not recorded
   assign w_unused = ^{i_trap_tval, i_trap_pc[1:0], i_mtvec[1:0], i_mepc[1:0]};
`endif

   csr_mstatus_xform #(.XLEN(XLEN)) u_mstatus_xform (
      .i_mstatus (i_mstatus),
      .i_mret    (r_state == SEQ_M_MSTATUS),
      .o_mstatus (w_mstatus_new)
   );

   // Sequencer state and trap-context capture; requests sampled only in IDLE
   // NOTE: sequential state uses non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= SEQ_IDLE;
         r_cause   <= '0;
         r_pc_hi   <= '0;
         r_is_trap <= 1'b0;
`ifdef CSR_SEQ_MTVAL_EN
         r_tval    <= '0;
`endif
      end else begin
         case (r_state)
            SEQ_IDLE: begin
               if (i_trap_req) begin
                  r_state   <= SEQ_T_MEPC;
                  r_cause   <= i_trap_cause;
                  r_pc_hi   <= i_trap_pc[W-1:2];
                  r_is_trap <= 1'b1;
`ifdef CSR_SEQ_MTVAL_EN
                  r_tval    <= i_trap_tval;
`endif
               end else if (i_mret_req) begin
                  r_state   <= SEQ_M_MSTATUS;
                  r_is_trap <= 1'b0;
               end
            end
            SEQ_T_MEPC:    r_state <= SEQ_T_MCAUSE;
`ifdef CSR_SEQ_MTVAL_EN
            SEQ_T_MCAUSE:  r_state <= SEQ_T_MTVAL;
            SEQ_T_MTVAL:   r_state <= SEQ_T_MSTATUS;
`else
            SEQ_T_MCAUSE:  r_state <= SEQ_T_MSTATUS;
`endif
            SEQ_T_MSTATUS: r_state <= SEQ_REDIR;
            SEQ_M_MSTATUS: r_state <= SEQ_REDIR;
            default:       r_state <= SEQ_IDLE;
         endcase
      end
   end

   // Write-port mux, acks and redirect decoded from state; all held low in reset
   always_comb begin
      o_trap_ack        = 1'b0;
      o_mret_ack        = 1'b0;
      o_instr_csr_grant = 1'b0;
      o_csr_we          = 1'b0;
      o_csr_addr        = '0;
      o_csr_wdata       = '0;
      o_flush           = 1'b0;
      o_redirect_valid  = 1'b0;
      o_redirect_pc     = '0;
      if (!i_rst) begin
         case (r_state)
            SEQ_IDLE: begin
               if (i_trap_req) begin
                  o_trap_ack = 1'b1;
               end else if (i_mret_req) begin
                  o_mret_ack = 1'b1;
               end else if (i_instr_csr_we) begin
                  o_instr_csr_grant = 1'b1;
                  o_csr_we          = 1'b1;
                  o_csr_addr        = i_instr_csr_addr;
                  o_csr_wdata       = i_instr_csr_data;
               end
            end
            SEQ_T_MEPC: begin
               o_csr_we    = 1'b1;
               o_csr_addr  = REG_MEPC_ADDR;
               o_csr_wdata = {r_pc_hi, 2'b00};
            end
            SEQ_T_MCAUSE: begin
               o_csr_we    = 1'b1;
               o_csr_addr  = REG_MCAUSE_ADDR;
               o_csr_wdata = {{(W-5){1'b0}}, r_cause};
            end
`ifdef CSR_SEQ_MTVAL_EN
            SEQ_T_MTVAL: begin
               o_csr_we    = 1'b1;
               o_csr_addr  = REG_MTVAL_ADDR;
               o_csr_wdata = r_tval;
            end
`endif
            SEQ_T_MSTATUS, SEQ_M_MSTATUS: begin
               o_csr_we    = 1'b1;
               o_csr_addr  = REG_MSTATUS_ADDR;
               o_csr_wdata = w_mstatus_new;
            end
            SEQ_REDIR: begin
               o_flush          = 1'b1;
               o_redirect_valid = 1'b1;
               o_redirect_pc    = r_is_trap ? {i_mtvec[W-1:2], 2'b00}
                                            : {i_mepc[W-1:2], 2'b00};
            end
            default: ;
         endcase
      end
   end

   // Stall covers pending requests as well as the running sequence
   assign o_stall = !i_rst && ((r_state != SEQ_IDLE) || i_trap_req || i_mret_req);

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Self-checking bench for csr_trap_sequencer (64-bit build). Expected CSR
// write sequences come from a reference model of the trap/MRET rules.
module tb_csr_trap_sequencer;

   localparam int W = 64;

   typedef struct {
      logic [11:0] addr;
      logic [63:0] data;
   } wr_t;

   logic         i_clk;
   logic         i_rst;
   logic         i_trap_req;
   logic [4:0]   i_trap_cause;
   logic [W-1:0] i_trap_pc;
   logic [W-1:0] i_trap_tval;
   logic         i_mret_req;
   logic         i_instr_csr_we;
   logic [11:0]  i_instr_csr_addr;
   logic [W-1:0] i_instr_csr_data;
   logic [W-1:0] i_mtvec;
   logic [W-1:0] i_mepc;
   logic [W-1:0] i_mstatus;
   logic         o_trap_ack;
   logic         o_mret_ack;
   logic         o_instr_csr_grant;
   logic         o_csr_we;
   logic [11:0]  o_csr_addr;
   logic [W-1:0] o_csr_wdata;
   logic         o_stall;
   logic         o_flush;
   logic         o_redirect_valid;
   logic [W-1:0] o_redirect_pc;

   int errors = 0;
   int checks = 0;

   csr_trap_sequencer dut (
      .i_clk             (i_clk),
      .i_rst             (i_rst),
      .i_trap_req        (i_trap_req),
      .i_trap_cause      (i_trap_cause),
      .i_trap_pc         (i_trap_pc),
      .i_trap_tval       (i_trap_tval),
      .i_mret_req        (i_mret_req),
      .i_instr_csr_we    (i_instr_csr_we),
      .i_instr_csr_addr  (i_instr_csr_addr),
      .i_instr_csr_data  (i_instr_csr_data),
      .i_mtvec           (i_mtvec),
      .i_mepc            (i_mepc),
      .i_mstatus         (i_mstatus),
      .o_trap_ack        (o_trap_ack),
      .o_mret_ack        (o_mret_ack),
      .o_instr_csr_grant (o_instr_csr_grant),
      .o_csr_we          (o_csr_we),
      .o_csr_addr        (o_csr_addr),
      .o_csr_wdata       (o_csr_wdata),
      .o_stall           (o_stall),
      .o_flush           (o_flush),
      .o_redirect_valid  (o_redirect_valid),
      .o_redirect_pc     (o_redirect_pc)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference rules for mstatus on trap entry and on MRET
   function automatic logic [63:0] ms_trap(input logic [63:0] ms);
      logic [63:0] r;
      r        = ms;
      r[7]     = ms[3];
      r[3]     = 1'b0;
      r[12:11] = 2'b11;
      return r;
   endfunction

   function automatic logic [63:0] ms_mret(input logic [63:0] ms);
      logic [63:0] r;
      r        = ms;
      r[3]     = ms[7];
      r[7]     = 1'b1;
      r[12:11] = 2'b11;
      return r;
   endfunction

   function automatic logic [63:0] align4(input logic [63:0] a);
      return a & ~64'h3;
   endfunction

   task automatic idle_inputs();
      i_trap_req     = 1'b0;
      i_mret_req     = 1'b0;
      i_instr_csr_we = 1'b0;
   endtask

   // Pipeline write while idle: same-cycle pass-through
   task automatic run_instr(input logic [11:0] addr, input logic [63:0] data);
      @(negedge i_clk);
      idle_inputs();
      i_instr_csr_we   = 1'b1;
      i_instr_csr_addr = addr;
      i_instr_csr_data = data;
      #1;
      check("instr_we",    o_csr_we, 1);
      check("instr_addr",  o_csr_addr, addr);
      check("instr_data",  o_csr_wdata, data);
      check("instr_grant", o_instr_csr_grant, 1);
      check("instr_stall", o_stall, 0);
      @(negedge i_clk);
      i_instr_csr_we = 1'b0;
      #1;
      check("instr_we_off", o_csr_we, 0);
      check("instr_grant_off", o_instr_csr_grant, 0);
   endtask

   // Trap entry, optionally racing an MRET and/or a pipeline write
   task automatic run_trap(input logic [4:0] cause, input logic [63:0] pc, input logic [63:0] tval,
                           input logic [63:0] ms, input logic [63:0] mtvec,
                           input bit with_mret, input bit with_instr);
      wr_t exp_q[$];
      exp_q.push_back('{12'h341, align4(pc)});
      exp_q.push_back('{12'h342, {59'd0, cause}});
`ifdef CSR_SEQ_MTVAL_EN
      exp_q.push_back('{12'h343, tval});
`endif
      exp_q.push_back('{12'h300, ms_trap(ms)});

      @(negedge i_clk);
      i_trap_req       = 1'b1;
      i_trap_cause     = cause;
      i_trap_pc        = pc;
      i_trap_tval      = tval;
      i_mstatus        = ms;
      i_mtvec          = mtvec;
      i_mepc           = {$urandom, $urandom};
      i_mret_req       = with_mret;
      i_instr_csr_we   = with_instr;
      i_instr_csr_addr = 12'h340;
      i_instr_csr_data = {$urandom, $urandom};
      #1;
      check("trap_ack",      o_trap_ack, 1);
      check("trap_mret_ack", o_mret_ack, 0);
      check("trap_grant",    o_instr_csr_grant, 0);
      check("trap_ack_we",   o_csr_we, 0);
      check("trap_ack_stall", o_stall, 1);
      @(negedge i_clk);
      idle_inputs();
      // Scramble the trap inputs: the sequence must use the captured values
      i_trap_cause = ~cause;
      i_trap_pc    = ~pc;
      i_trap_tval  = ~tval;
      foreach (exp_q[k]) begin
         #1;
         check("trap_we",    o_csr_we, 1);
         check("trap_addr",  o_csr_addr, exp_q[k].addr);
         check("trap_wdata", o_csr_wdata, exp_q[k].data);
         check("trap_stall", o_stall, 1);
         check("trap_no_redir", o_redirect_valid, 0);
         @(negedge i_clk);
      end
      #1;
      check("trap_redir_valid", o_redirect_valid, 1);
      check("trap_redir_pc",    o_redirect_pc, align4(mtvec));
      check("trap_flush",       o_flush, 1);
      check("trap_redir_we",    o_csr_we, 0);
      @(negedge i_clk);
      #1;
      check("trap_done_stall", o_stall, 0);
      check("trap_done_redir", o_redirect_valid, 0);
      check("trap_done_flush", o_flush, 0);
   endtask

   // MRET, optionally racing a pipeline write
   task automatic run_mret(input logic [63:0] ms, input logic [63:0] mepc, input bit with_instr);
      @(negedge i_clk);
      i_mret_req       = 1'b1;
      i_mstatus        = ms;
      i_mepc           = mepc;
      i_mtvec          = {$urandom, $urandom};
      i_instr_csr_we   = with_instr;
      i_instr_csr_addr = 12'h305;
      i_instr_csr_data = {$urandom, $urandom};
      #1;
      check("mret_ack",       o_mret_ack, 1);
      check("mret_trap_ack",  o_trap_ack, 0);
      check("mret_grant",     o_instr_csr_grant, 0);
      check("mret_ack_we",    o_csr_we, 0);
      check("mret_ack_stall", o_stall, 1);
      @(negedge i_clk);
      idle_inputs();
      #1;
      check("mret_we",    o_csr_we, 1);
      check("mret_addr",  o_csr_addr, 12'h300);
      check("mret_wdata", o_csr_wdata, ms_mret(ms));
      check("mret_stall", o_stall, 1);
      @(negedge i_clk);
      #1;
      check("mret_redir_valid", o_redirect_valid, 1);
      check("mret_redir_pc",    o_redirect_pc, align4(mepc));
      check("mret_flush",       o_flush, 1);
      check("mret_redir_we",    o_csr_we, 0);
      @(negedge i_clk);
      #1;
      check("mret_done_stall", o_stall, 0);
      check("mret_done_redir", o_redirect_valid, 0);
   endtask

   initial begin
      logic [4:0] codes [9];
      codes = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd11};

      // Reset with requests present: every output must stay low
      i_rst            = 1'b1;
      i_trap_req       = 1'b1;
      i_trap_cause     = 5'd3;
      i_trap_pc        = 64'h1234;
      i_trap_tval      = 64'h5678;
      i_mret_req       = 1'b1;
      i_instr_csr_we   = 1'b1;
      i_instr_csr_addr = 12'h340;
      i_instr_csr_data = 64'hFF;
      i_mtvec          = 64'h8000_0001;
      i_mepc           = 64'h8000_0106;
      i_mstatus        = 64'h8;
      #12;
      check("rst_trap_ack", o_trap_ack, 0);
      check("rst_mret_ack", o_mret_ack, 0);
      check("rst_grant",    o_instr_csr_grant, 0);
      check("rst_we",       o_csr_we, 0);
      check("rst_addr",     o_csr_addr, 0);
      check("rst_wdata",    o_csr_wdata, 0);
      check("rst_stall",    o_stall, 0);
      check("rst_flush",    o_flush, 0);
      check("rst_redir",    o_redirect_valid, 0);
      check("rst_redir_pc", o_redirect_pc, 0);
      idle_inputs();
      @(negedge i_clk);
      i_rst = 1'b0;

      // Pipeline writes
      run_instr(12'h340, 64'hAB);
      for (int i = 0; i < 4; i++)
         run_instr(12'($urandom), {$urandom, $urandom});

      // Directed trap and MRET vectors
      run_trap(5'd2, 64'h8000_0104, 64'hDEAD, 64'h8, 64'h8000_0001, 1'b0, 1'b0);
      run_mret(64'h1880, 64'h8000_0106, 1'b0);

      // Randomized traps and MRETs
      for (int i = 0; i < 6; i++) begin
         run_trap(codes[$urandom_range(0, 8)], {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 1'($urandom));
         run_mret({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      end

      // Trap, MRET and pipeline write in the same cycle: trap alone wins
      run_trap(5'd11, 64'h8000_0200, 64'h0, 64'h88, 64'h8000_1000, 1'b1, 1'b1);
      run_instr(12'h341, 64'h55);

      // Reset asserted while the mcause write is on the port
      @(negedge i_clk);
      i_trap_req   = 1'b1;
      i_trap_cause = 5'd5;
      i_trap_pc    = 64'h8000_0300;
      i_trap_tval  = 64'hBEEF;
      @(negedge i_clk);
      idle_inputs();
      @(negedge i_clk);
      #1;
      check("mid_mcause_addr", o_csr_addr, 12'h342);
      i_rst = 1'b1;
      #1;
      check("mid_rst_we",    o_csr_we, 0);
      check("mid_rst_addr",  o_csr_addr, 0);
      check("mid_rst_wdata", o_csr_wdata, 0);
      check("mid_rst_stall", o_stall, 0);
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("post_rst_redir", o_redirect_valid, 0);
         check("post_rst_we",    o_csr_we, 0);
         check("post_rst_stall", o_stall, 0);
         @(negedge i_clk);
      end
      run_instr(12'h300, 64'h1800);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
